// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
// All segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // One complete display image: four BCD nibbles, enables and decimal points.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  en;
        logic [3:0]  dp;
    } disp_cfg_t;

endpackage

// File: rtl/bcd_7.sv
// BCD-to-7-segment decoder, active-low outputs; non-BCD codes decode to blank.
module bcd_7
    import seg_pkg::*;
(
    input  logic [3:0] sw,
    output logic [6:0] out
);

    always_comb begin
        case (sw)
            4'd0:    out = SEG_0;
            4'd1:    out = SEG_1;
            4'd2:    out = SEG_2;
            4'd3:    out = SEG_3;
            4'd4:    out = SEG_4;
            4'd5:    out = SEG_5;
            4'd6:    out = SEG_6;
            4'd7:    out = SEG_7;
            4'd8:    out = SEG_8;
            4'd9:    out = SEG_9;
            default: out = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller: one shared decoder, anti-ghost
// blanking at the start of each slot, and a shadow image swapped only at frame end.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYC = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        frame_done,
    output logic [3:0]  anode,
    output logic [6:0]  out,
    output logic        dp
);

    localparam int CNT_W = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    disp_cfg_t        pending;
    disp_cfg_t        active;
    logic             pending_valid;

    logic             slot_end;
    logic             frame_end;
    logic             in_blank;
    logic [3:0]       nibble;
    logic [6:0]       dec_out;
    logic [3:0]       anode_nxt;
    logic [6:0]       out_nxt;
    logic             dp_nxt;

    assign slot_end  = (cnt == CNT_W'(DIGIT_CYC - 1));
    assign frame_end = slot_end && (idx == 2'd3);
    assign in_blank  = (cnt < CNT_W'(BLANK_CYC));
    assign nibble    = active.digits[{idx, 2'b00} +: 4];

    bcd_7 u_dec (
        .sw  (nibble),
        .out (dec_out)
    );

    // Disabled digits keep their anode and decimal point; only the segments go dark.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        anode_nxt = ANODE_OFF;
        out_nxt   = SEG_BLANK;
        dp_nxt    = 1'b1;
        if (!in_blank) begin
            anode_nxt = ~(4'b0001 << idx);
            dp_nxt    = ~active.dp[idx];
            if (active.en[idx])
                out_nxt = dec_out;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            idx           <= 2'd0;
            pending       <= '0;
            active        <= '0;
            pending_valid <= 1'b0;
            frame_done    <= 1'b0;
            anode         <= ANODE_OFF;
            out           <= SEG_BLANK;
            dp            <= 1'b1;
        end else begin
            anode      <= anode_nxt;
            out        <= out_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_end;

            if (slot_end) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // The boundary moves the old pending image; a coincident load refills pending.
            if (frame_end && pending_valid)
                active <= pending;

            if (load) begin
                pending       <= '{digits: digits, en: digit_en, dp: dp_in};
                pending_valid <= 1'b1;
            end else if (frame_end) begin
                pending_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with an 8-cycle slot and 2 blank cycles.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        frame_done;
    logic [3:0]  anode;
    logic [6:0]  out;
    logic        dp;

    int tests = 0;
    int fails = 0;

    seg_scan_ctrl #(.DIGIT_CYC(8), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .load       (load),
        .frame_done (frame_done),
        .anode      (anode),
        .out        (out),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // Called right after a negedge; the strobe is seen by exactly one posedge.
    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpv);
        digits   = d;
        digit_en = en;
        dp_in    = dpv;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if ({anode, out, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL %s: anode=%b out=%h dp=%b frame_done=%b, want anode=1111 out=7f dp=1 frame_done=0",
                     name, anode, out, dp, frame_done);
        end
    endtask

    task automatic wait_frame_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: frame_done=0 after 100 cycles, want a pulse", name);
        end
    endtask

    // Starts at a frame_done sample point and checks the 32 following cycles.
    // segs holds the expected pattern per digit, digit3 in the top 7 bits.
    task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] dpv);
        for (int k = 1; k <= 32; k++) begin
            int s;
            int pos;
            logic [3:0] exp_an;
            logic [6:0] exp_out;
            logic       exp_dp;
            logic       exp_fd;
            @(negedge clk);
            s   = (k - 1) / 8;
            pos = (k - 1) % 8;
            if (pos < 2) begin
                exp_an  = 4'hF;
                exp_out = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = ~(4'b0001 << s);
                exp_out = segs[s*7 +: 7];
                exp_dp  = ~dpv[s];
            end
            exp_fd = (k == 32);
            tests++;
            if ({anode, out, dp, frame_done} !== {exp_an, exp_out, exp_dp, exp_fd}) begin
                fails++;
                $display("FAIL %s cycle %0d: anode=%b out=%h dp=%b frame_done=%b, want anode=%b out=%h dp=%b frame_done=%b",
                         name, k, anode, out, dp, frame_done, exp_an, exp_out, exp_dp, exp_fd);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("reset_held");
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_digits();
        do_load(16'h1234, 4'b1111, 4'b0000);
        wait_frame_done("digits_boundary");
        check_frame("digits_1234_f1", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
        check_frame("digits_1234_f2", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    endtask

    task automatic test_blanking();
        // digit0 F and digit2 A blank by code, digit1 blank by enable, digit3 shows 9.
        do_load(16'h9A0F, 4'b1101, 4'b0000);
        wait_frame_done("blank_boundary");
        check_frame("blank_9A0F", {7'h10, 7'h7F, 7'h7F, 7'h7F}, 4'b0000);
    endtask

    task automatic test_dp();
        do_load(16'h8888, 4'b1111, 4'b0101);
        wait_frame_done("dp_boundary");
        check_frame("dp_0101", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0101);
    endtask

    task automatic test_back_to_back();
        fork
            check_frame("b2b_current", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0101);
            begin
                repeat (5) @(negedge clk);
                do_load(16'h1111, 4'b1111, 4'b0000);
                @(negedge clk);
                do_load(16'h2222, 4'b1111, 4'b0000);
            end
        join
        check_frame("b2b_last_wins", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000);
    endtask

    task automatic test_load_at_boundary();
        fork
            check_frame("bnd_current", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000);
            begin
                repeat (20) @(negedge clk);
                do_load(16'h3333, 4'b1111, 4'b0000);
                repeat (10) @(negedge clk);
                do_load(16'h5555, 4'b1111, 4'b0000);
            end
        join
        check_frame("bnd_old_pending", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b0000);
        check_frame("bnd_new_pending", {7'h12, 7'h12, 7'h12, 7'h12}, 4'b0000);
    endtask

    task automatic test_reset_mid_scan();
        repeat (10) @(negedge clk);
        do_load(16'h7777, 4'b1111, 4'b1111);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midscan_reset");
        rst = 1'b0;
        check_frame("post_reset_f1", {4{7'h7F}}, 4'b0000);
        check_frame("post_reset_f2", {4{7'h7F}}, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_digits();
        test_blanking();
        test_dp();
        test_back_to_back();
        test_load_at_boundary();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
